// File: rtl/write_region.sv
// write_region: buffers a stream of upstream lines and writes them into the local region
// as BRAM writes, FIFO pushes or both, running one configured operation at a time.
module write_region #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 14,
  parameter int BUF_DEPTH  = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  input  logic [15:0]           iterations,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_almostfull,
  output logic                  region_we,
  output logic [1:0]            region_wfifobram,
  output logic [ADDR_WIDTH-1:0] region_waddr,
  output logic [DATA_WIDTH-1:0] region_wdata,
  input  logic                  region_almostfull,
  output logic                  op_done,
  output logic                  busy,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(BUF_DEPTH - AF_MARGIN);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t state_r, state_next_s;

  // input skid buffer
  logic [DATA_WIDTH-1:0] buf_mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r, count_next_s;
  logic                  full_s, empty_s, push_s, pop_s, drop_s;
  logic                  in_almostfull_r, overflow_r;

  // latched operation and progress counters
  logic [ADDR_WIDTH-1:0] offset_r, length_r, line_cnt_r;
  logic                  keep_r;
  logic [1:0]            tgt_r;
  logic [15:0]           iters_r, iter_cnt_r;

  // configuration decode and control strobes
  logic [ADDR_WIDTH-1:0] cfg_offset_s, cfg_length_s;
  logic                  unused_cfg_s;
  logic                  start_idle_s, degenerate_s, issue_s;
  logic                  last_line_s, last_iter_s, finish_s;

  // registered region-side outputs
  logic                  region_we_r, op_done_r, busy_r;
  logic [1:0]            region_wfifobram_r;
  logic [ADDR_WIDTH-1:0] region_waddr_r;
  logic [DATA_WIDTH-1:0] region_wdata_r;

  assign cfg_offset_s = ADDR_WIDTH'(configreg[13:0]);
  assign cfg_length_s = ADDR_WIDTH'(configreg[29:16]);
  assign unused_cfg_s = configreg[14];

  assign full_s  = (count_r == FULL_LVL);
  assign empty_s = (count_r == {CNT_W{1'b0}});

  assign start_idle_s = (state_r == ST_IDLE) && op_start;
  assign degenerate_s = (cfg_length_s == {ADDR_WIDTH{1'b0}}) || (iterations == 16'd0) ||
                        (configreg[31:30] == 2'b00);

  // A FIFO-targeted write waits for room; BRAM-only writes never stall.
  assign issue_s = (state_r == ST_WRITE) && !empty_s && (!tgt_r[1] || !region_almostfull);

  assign last_line_s = (line_cnt_r == (length_r - ADDR_WIDTH'(1)));
  assign last_iter_s = (iter_cnt_r == (iters_r - 16'd1));
  assign finish_s    = issue_s && last_line_s && last_iter_s;

  // The pop frees a slot first, so a push into a full buffer that is being drained is kept.
  assign pop_s  = issue_s;
  assign push_s = in_valid && (!full_s || pop_s);
  assign drop_s = in_valid && full_s && !pop_s;

  // Next state of the operation sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (op_start && !degenerate_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (finish_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WRITE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Occupancy after this cycle's push and pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Buffer storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Buffer pointers, occupancy, backpressure and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r        <= {PTR_W{1'b0}};
      rd_ptr_r        <= {PTR_W{1'b0}};
      count_r         <= {CNT_W{1'b0}};
      in_almostfull_r <= 1'b0;
      overflow_r      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r         <= count_next_s;
      in_almostfull_r <= (count_next_s >= AF_LVL);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Operation parameters and line/iteration progress
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_r   <= {ADDR_WIDTH{1'b0}};
      length_r   <= {ADDR_WIDTH{1'b0}};
      keep_r     <= 1'b0;
      tgt_r      <= 2'b00;
      iters_r    <= 16'd0;
      line_cnt_r <= {ADDR_WIDTH{1'b0}};
      iter_cnt_r <= 16'd0;
    end else if (start_idle_s) begin
      offset_r   <= cfg_offset_s;
      length_r   <= cfg_length_s;
      keep_r     <= configreg[15];
      tgt_r      <= configreg[31:30];
      iters_r    <= iterations;
      line_cnt_r <= {ADDR_WIDTH{1'b0}};
      iter_cnt_r <= 16'd0;
    end else if (issue_s) begin
      if (last_line_s) begin
        line_cnt_r <= {ADDR_WIDTH{1'b0}};
        iter_cnt_r <= iter_cnt_r + 16'd1;
        if (keep_r) begin
          offset_r <= offset_r + length_r;
        end
      end else begin
        line_cnt_r <= line_cnt_r + ADDR_WIDTH'(1);
      end
    end
  end

  // Registered region write port and status
  always_ff @(posedge clk) begin
    if (reset) begin
      region_we_r        <= 1'b0;
      region_wfifobram_r <= 2'b00;
      region_waddr_r     <= {ADDR_WIDTH{1'b0}};
      region_wdata_r     <= {DATA_WIDTH{1'b0}};
      op_done_r          <= 1'b0;
      busy_r             <= 1'b0;
    end else begin
      region_we_r <= issue_s;
      if (issue_s) begin
        region_wfifobram_r <= tgt_r;
        region_waddr_r     <= offset_r + line_cnt_r;
        region_wdata_r     <= buf_mem_r[rd_ptr_r];
      end
      op_done_r <= finish_s || (start_idle_s && degenerate_s);
      busy_r    <= (state_next_s == ST_WRITE);
    end
  end

  assign in_almostfull    = in_almostfull_r;
  assign overflow         = overflow_r;
  assign region_we        = region_we_r;
  assign region_wfifobram = region_wfifobram_r;
  assign region_waddr     = region_waddr_r;
  assign region_wdata     = region_wdata_r;
  assign op_done          = op_done_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_write_region.sv
// Directed bench for write_region: hand-computed addresses, data, flags and timing per scenario.
module tb_write_region;

  localparam int DW = 512;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_start;
  logic [31:0]   configreg;
  logic [15:0]   iterations;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_almostfull;
  logic          region_we;
  logic [1:0]    region_wfifobram;
  logic [AW-1:0] region_waddr;
  logic [DW-1:0] region_wdata;
  logic          region_almostfull;
  logic          op_done;
  logic          busy;
  logic          overflow;

  write_region dut (
    .clk               (clk),
    .reset             (reset),
    .op_start          (op_start),
    .configreg         (configreg),
    .iterations        (iterations),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_almostfull     (in_almostfull),
    .region_we         (region_we),
    .region_wfifobram  (region_wfifobram),
    .region_waddr      (region_waddr),
    .region_wdata      (region_wdata),
    .region_almostfull (region_almostfull),
    .op_done           (op_done),
    .busy              (busy),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // write log filled on the falling edge
  int            cyc = 0;
  int            n_log = 0;
  int            done_cnt = 0;
  int            stall_viol = 0;
  logic          ra_q = 1'b0;
  logic [AW-1:0] lg_addr [0:127];
  logic [DW-1:0] lg_data [0:127];
  logic [1:0]    lg_wfb  [0:127];
  logic          lg_done [0:127];
  int            lg_cyc  [0:127];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ra_q <= region_almostfull;
  end

  always @(negedge clk) begin
    if (op_done) done_cnt <= done_cnt + 1;
    if (region_we) begin
      if (ra_q && region_wfifobram[1]) stall_viol <= stall_viol + 1;
      if (n_log < 128) begin
        lg_addr[n_log] <= region_waddr;
        lg_data[n_log] <= region_wdata;
        lg_wfb[n_log]  <= region_wfifobram;
        lg_done[n_log] <= op_done;
        lg_cyc[n_log]  <= cyc;
      end
      n_log <= n_log + 1;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk_line(input int v);
    return {16{v}};
  endfunction

  function automatic logic [31:0] mk_cfg(input logic [13:0] off, input logic keep,
                                         input logic [13:0] len, input logic bram,
                                         input logic fifo);
    return {fifo, bram, len, keep, 1'b0, off};
  endfunction

  task automatic start_op(input logic [31:0] cfg, input logic [15:0] it);
    configreg  = cfg;
    iterations = it;
    op_start   = 1'b1;
    tick();
    op_start   = 1'b0;
  endtask

  task automatic push_lines(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = mk_line(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick();
      i++;
    end
    tick();
    chk(tag, DW'(done_cnt - d0), DW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d0;
    int t_in;

    reset = 1'b1; op_start = 1'b0; configreg = 32'd0; iterations = 16'd0;
    in_valid = 1'b0; in_data = '0; region_almostfull = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_we",   DW'(region_we), DW'(0));
    chk("rst_wfb",  DW'(region_wfifobram), DW'(0));
    chk("rst_addr", DW'(region_waddr), DW'(0));
    chk("rst_data", region_wdata, DW'(0));
    chk("rst_af",   DW'(in_almostfull), DW'(0));
    chk("rst_misc", DW'({op_done, busy, overflow}), DW'(0));

    // BRAM, offset 100, length 4, one iteration, back-to-back lines
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd100, 1'b0, 14'd4, 1'b1, 1'b0), 16'd1);
    chk("t1_busy", DW'(busy), DW'(1));
    t_in = cyc;
    push_lines(4, 100);
    wait_done(d0, 30, "t1_done");
    chk("t1_n", DW'(n_log - base), DW'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", DW'(lg_addr[base+i]), DW'(100 + i));
      chk("t1_data", lg_data[base+i], mk_line(100 + i));
      chk("t1_wfb",  DW'(lg_wfb[base+i]), DW'(2'b01));
      chk("t1_dflag", DW'(lg_done[base+i]), DW'(i == 3));
    end
    chk("t1_lat",  DW'(lg_cyc[base] - t_in), DW'(2));
    chk("t1_span", DW'(lg_cyc[base+3] - lg_cyc[base]), DW'(3));
    chk("t1_busy_end", DW'(busy), DW'(0));

    // keep_count = 1: offset advances by length each iteration
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd10, 1'b1, 14'd3, 1'b1, 1'b0), 16'd3);
    push_lines(9, 200);
    wait_done(d0, 40, "t2k_done");
    chk("t2k_n", DW'(n_log - base), DW'(9));
    for (int i = 0; i < 9; i++) begin
      chk("t2k_addr", DW'(lg_addr[base+i]), DW'(10 + i));
      chk("t2k_data", lg_data[base+i], mk_line(200 + i));
    end

    // keep_count = 0: same addresses every iteration
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd10, 1'b0, 14'd3, 1'b1, 1'b0), 16'd3);
    push_lines(9, 220);
    wait_done(d0, 40, "t2n_done");
    chk("t2n_n", DW'(n_log - base), DW'(9));
    for (int i = 0; i < 9; i++) begin
      chk("t2n_addr", DW'(lg_addr[base+i]), DW'(10 + (i % 3)));
    end

    // address wrap, both targets
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd16383, 1'b0, 14'd2, 1'b1, 1'b1), 16'd1);
    push_lines(2, 250);
    wait_done(d0, 20, "wrap_done");
    chk("wrap_a0", DW'(lg_addr[base]), DW'(16383));
    chk("wrap_a1", DW'(lg_addr[base+1]), DW'(0));
    chk("wrap_wfb", DW'(lg_wfb[base]), DW'(2'b11));

    // FIFO target with region_almostfull high for four cycles mid-stream
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd0, 1'b0, 14'd8, 1'b0, 1'b1), 16'd1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = mk_line(300 + i);
      region_almostfull = (i >= 2 && i <= 5);
      tick();
    end
    in_valid = 1'b0;
    region_almostfull = 1'b0;
    wait_done(d0, 40, "t3_done");
    chk("t3_n", DW'(n_log - base), DW'(8));
    chk("t3_stall", DW'(stall_viol), DW'(0));
    chk("t3_span", DW'(lg_cyc[base+7] - lg_cyc[base]), DW'(11));
    for (int i = 0; i < 8; i++) begin
      chk("t3_data", lg_data[base+i], mk_line(300 + i));
      chk("t3_wfb",  DW'(lg_wfb[base+i]), DW'(2'b10));
    end

    // no drain: 20 lines into the 16-entry buffer
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b1;
      in_data  = mk_line(400 + k - 1);
      tick();
      if (k == 11) chk("t4_af11", DW'(in_almostfull), DW'(0));
      if (k == 12) chk("t4_af12", DW'(in_almostfull), DW'(1));
      if (k == 16) chk("t4_ovf16", DW'(overflow), DW'(0));
      if (k == 17) chk("t4_ovf17", DW'(overflow), DW'(1));
    end
    in_valid = 1'b0;
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd500, 1'b0, 14'd16, 1'b1, 1'b0), 16'd1);
    wait_done(d0, 40, "t4_done");
    chk("t4_n", DW'(n_log - base), DW'(16));
    for (int i = 0; i < 16; i++) begin
      chk("t4_data", lg_data[base+i], mk_line(400 + i));
    end
    chk("t4_af_end", DW'(in_almostfull), DW'(0));
    chk("t4_ovf_sticky", DW'(overflow), DW'(1));

    // degenerate operations complete immediately without writing
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd5, 1'b0, 14'd0, 1'b1, 1'b0), 16'd2);
    chk("t5_len0_done", DW'(op_done), DW'(1));
    chk("t5_len0_busy", DW'(busy), DW'(0));
    tick();
    chk("t5_len0_pulse", DW'(op_done), DW'(0));
    start_op(mk_cfg(14'd5, 1'b0, 14'd4, 1'b0, 1'b0), 16'd2);
    chk("t5_tgt0_done", DW'(op_done), DW'(1));
    chk("t5_tgt0_busy", DW'(busy), DW'(0));
    tick();
    chk("t5_nowr", DW'(n_log - base), DW'(0));
    chk("t5_dcnt", DW'(done_cnt - d0), DW'(2));

    // reset during WRITE after 2 of 5 lines, with one more line buffered
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd200, 1'b0, 14'd5, 1'b1, 1'b0), 16'd1);
    push_lines(2, 500);
    tick(); tick();
    chk("t6_two", DW'(n_log - base), DW'(2));
    in_valid = 1'b1;
    in_data  = mk_line(502);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t6_we",   DW'(region_we), DW'(0));
    chk("t6_port", DW'({region_wfifobram, region_waddr}), DW'(0));
    chk("t6_data", region_wdata, DW'(0));
    chk("t6_flags", DW'({in_almostfull, op_done, busy, overflow}), DW'(0));
    reset = 1'b0;
    tick();
    chk("t6_nodone", DW'(done_cnt - d0), DW'(0));
    chk("t6_nowr", DW'(n_log - base), DW'(2));
    base = n_log; d0 = done_cnt;
    start_op(mk_cfg(14'd300, 1'b0, 14'd5, 1'b1, 1'b0), 16'd1);
    push_lines(5, 600);
    wait_done(d0, 30, "t6_done");
    chk("t6_n", DW'(n_log - base), DW'(5));
    for (int i = 0; i < 5; i++) begin
      chk("t6_addr", DW'(lg_addr[base+i]), DW'(300 + i));
      chk("t6_rdata", lg_data[base+i], mk_line(600 + i));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/write_region.md
# write_region

Write-side counterpart of the region read stage: consumes a stream of cache lines from an upstream compute/load stage and writes them into a local region, as BRAM at computed addresses, as FIFO pushes, or both. It sits directly upstream of the region storage that the read stage later drains. It runs one configured operation at a time (offset, length, iterations), with optional offset advance between iterations. A 16-entry input skid buffer with early backpressure decouples the producer's pipeline latency from region-side stalls.

## Interface
- DATA_WIDTH, 512: line width in bits.
- ADDR_WIDTH, 14: region address width; offset and length fields use this width.
- BUF_DEPTH, 16: input buffer entries (power of two).
- AF_MARGIN, 4: free entries remaining when `in_almostfull` asserts.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- op_start  in  1  start pulse; sampled only in IDLE.
- configreg  in  32  [13:0] offset, [14] reserved (ignored), [15] keep_count_along_iterations, [29:16] length in lines, [30] write_bram, [31] write_fifo.
- iterations  in  16  number of length-line iterations.
- in_valid  in  1  upstream line valid.
- in_data  in  DATA_WIDTH  upstream line.
- in_almostfull  out  1  backpressure to upstream.
- region_we  out  1  region write strobe.
- region_wfifobram  out  2  01 = BRAM, 10 = FIFO, 11 = both.
- region_waddr  out  ADDR_WIDTH  BRAM address; don't-care for FIFO-only writes.
- region_wdata  out  DATA_WIDTH  line written.
- region_almostfull  in  1  region FIFO cannot take more pushes.
- op_done  out  1  one-cycle completion pulse.
- busy  out  1  high while an operation is active.
- overflow  out  1  sticky; a line arrived while the buffer was full.

## Operation
- States: IDLE, WRITE.
- Input buffer:
  - Accepts `in_valid` lines in any state whenever it is not full.
  - A line arriving while the buffer is full is dropped and sets `overflow`.
  - `in_almostfull` is `count >= BUF_DEPTH-AF_MARGIN`.
- IDLE + `op_start`: latch offset, length, keep_count, targets and iterations; clear line and iteration counters.
  - If length == 0, iterations == 0, or [31:30] == 00, stay in IDLE and pulse `op_done` next cycle.
  - Otherwise go to WRITE; `busy` = 1.
- WRITE issues one write per cycle when all of these hold:
  - buffer is non-empty;
  - BRAM-only target, or `region_almostfull` = 0 when the FIFO is targeted.
- On issue:
  - pop the buffer head;
  - `region_we` = 1, `region_wfifobram` = {write_fifo, write_bram}, `region_waddr` = offset + line_count (mod 2^ADDR_WIDTH), `region_wdata` = popped line;
  - line_count++.
- At line_count == length-1 on issue, the iteration ends:
  - iteration_count++ and line_count = 0;
  - if keep_count is set, offset += length (mod 2^ADDR_WIDTH).
  - If iteration_count == iterations-1: `op_done` pulses with this write, state goes to IDLE, `busy` drops next cycle.
- `op_start` outside IDLE is ignored.
- Lines left in the buffer after done are kept for the next operation.
- `overflow` clears only on reset.

## Timing
- All outputs are registered.
- Reset values: `region_we` 0, `region_wfifobram` 00, `region_waddr` 0, `region_wdata` 0, `in_almostfull` 0, `op_done` 0, `busy` 0, `overflow` 0.
- Reset also sets state IDLE, empties the buffer and clears all counters.
- Reset mid-operation aborts with no `op_done` pulse.
- Latency: `in_valid` at edge t, in WRITE and unstalled, gives `region_we` at edge t+2.
- Throughput: one line per cycle.
- Simultaneous push and pop on a full buffer: the pop frees a slot first, so the push is accepted and `overflow` is not set.
- `region_almostfull` is sampled in the issue cycle. A write issued while it is low is never retracted; the region absorbs one in-flight write.
- `in_almostfull` reflects count after the current cycle's push and pop, one cycle late. The upstream stage must stop within AF_MARGIN-1 cycles.
- `op_start` accepted at edge t: `busy` = 1 at t+1; first write no earlier than t+2.
- Address arithmetic wraps: offset 16383 + 1 → 0.

## Test plan
- BRAM, offset 100, length 4, iterations 1, 4 back-to-back lines → writes at 100..103 in consecutive cycles, wfifobram 01, `op_done` with the write at 103.
- keep_count = 1, offset 10, length 3, iterations 3 → addresses 10..18 contiguous. keep_count = 0 with the same setup → 10,11,12 three times.
- FIFO target, length 8, `region_almostfull` high for cycles 3–6 → no `region_we` in those cycles, all 8 lines in order, none lost.
- Hold the drain stalled and push 20 lines → `in_almostfull` high once count ≥ 12, lines 17–20 dropped, `overflow` = 1, first 16 written in order.
- length 0 or targets 00 → no writes, `op_done` one cycle after `op_start`, `busy` stays 0.
- Reset asserted mid-WRITE after 2 of 5 lines → all outputs 0 next cycle, buffer empty, no `op_done`. A new `op_start` then runs normally.
